// File: rtl/read_req_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | read_req_queue_pkg : FSM state encoding and line width for RRQ    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package read_req_queue_pkg;

  localparam int LINE_W = 128;
  localparam int RID_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_ISS = 2'd2
  } rrq_state_e;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/read_req_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | read_req_queue_if : requester/manager/data bundle; RRQ_ERR_CHECK_EN|
// | adds rq_err.  Rev 1.0                                             |
// +------------------------------------------------------------------+
interface read_req_queue_if #(
  parameter int TAG_W = 4
);
  import read_req_queue_pkg::*;

  logic                 rd_req;
  logic [31:0]          rd_addr;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_ack;
  logic                 rstart_rq;
  logic [31:0]          rin_addr;
  logic                 rnext_rq;
  logic [RID_W-1:0]     rnext_id;
  logic                 next_rrq;
  logic [RID_W-1:0]     next_rid;
  logic                 rqfull_1;
  logic [LINE_W-1:0]    rdat_m_data;
  logic                 rdat_m_valid;
  logic                 finish_mrd;
  logic [LINE_W-1:0]    rd_rdata;
  logic                 rd_rvalid;
  logic [TAG_W-1:0]     rd_rtag;
`ifdef RRQ_ERR_CHECK_EN
  logic                 rq_err;
`endif

  modport slave (
    input  rd_req, rd_addr, rd_tag, rnext_rq, rnext_id,
           rdat_m_data, rdat_m_valid, finish_mrd,
`ifdef RRQ_ERR_CHECK_EN
    output rq_err,
`endif
    output rd_ack, rstart_rq, rin_addr, next_rrq, next_rid, rqfull_1,
           rd_rdata, rd_rvalid, rd_rtag
  );

  modport master (
    output rd_req, rd_addr, rd_tag, rnext_rq, rnext_id,
           rdat_m_data, rdat_m_valid, finish_mrd,
`ifdef RRQ_ERR_CHECK_EN
    input  rq_err,
`endif
    input  rd_ack, rstart_rq, rin_addr, next_rrq, next_rid, rqfull_1,
           rd_rdata, rd_rvalid, rd_rtag
  );

endinterface
`default_nettype wire

// File: rtl/read_req_queue_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rrq_fifo : outstanding-read FIFO, power-of-two DEPTH, wrap ptrs   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rrq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CNT_MAX) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/read_req_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | read_req_queue : read request sequencer + tagged return queue;    |
// | RRQ_ERR_CHECK_EN adds sticky rq_err.  Rev 1.0                     |
// +------------------------------------------------------------------+
module read_req_queue
  import read_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  read_req_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = RID_W + TAG_W;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL1 = CNT_W'(DEPTH - 1);

  rrq_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rstart_q, rstart_d;
  logic [31:0]       rin_addr_q, rin_addr_d;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [LINE_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [TAG_W-1:0]  rtag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tag_q      <= '0;
      rd_ack_q   <= 1'b0;
      rstart_q   <= 1'b0;
      rin_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      rd_ack_q   <= rd_ack_d;
      rstart_q   <= rstart_d;
      rin_addr_q <= rin_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    rd_ack_d   = 1'b0;
    rstart_d   = 1'b0;
    rin_addr_d = rin_addr_q;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd_req && (count < CNT_MAX)) begin
          rd_ack_d = 1'b1;
          addr_d   = line_align(bus.rd_addr);
          tag_d    = bus.rd_tag;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        rstart_d   = 1'b1;
        rin_addr_d = addr_q;
        state_d    = ST_WAIT_ISS;
      end
      ST_WAIT_ISS: begin
        if (bus.rnext_rq) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = bus.finish_mrd && !empty;

  rrq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({bus.rnext_id, tag_q}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rtag_q   <= '0;
    end else begin
      if (bus.rdat_m_valid) rdata_q <= bus.rdat_m_data;
      rvalid_q <= pop;
      if (pop) rtag_q <= head[TAG_W-1:0];
    end
  end

`ifdef RRQ_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((bus.finish_mrd && empty) || (bus.rnext_rq && (count == CNT_MAX))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rq_err = err_q;
`endif

  assign bus.rd_ack    = rd_ack_q;
  assign bus.rstart_rq = rstart_q;
  assign bus.rin_addr  = rin_addr_q;
  assign bus.next_rrq  = !empty;
  // Gate the head ID so an empty queue never exposes stale storage.
  assign bus.next_rid  = empty ? '0 : head[ENT_W-1 -: RID_W];
  assign bus.rqfull_1  = (count >= CNT_FULL1);
  assign bus.rd_rdata  = rdata_q;
  assign bus.rd_rvalid = rvalid_q;
  assign bus.rd_rtag   = rtag_q;

endmodule
`default_nettype wire
